// File: rtl/ddr3_ref_arb_pkg.sv
// ddr3_ref_arb_pkg: shared definitions for the DDR3 refresh scheduler / command arbiter.
//   - DDR command encodings {ras_n, cas_n, we_n}
//   - arbiter state encoding
//   - field widths shared by the command interface
package ddr3_ref_arb_pkg;

    localparam int unsigned CMD_BITS = 3;
    localparam int unsigned BA_BITS  = 3;

    localparam logic [CMD_BITS-1:0] CMD_NOOP = 3'b111;
    localparam logic [CMD_BITS-1:0] CMD_PREC = 3'b010;
    localparam logic [CMD_BITS-1:0] CMD_REFR = 3'b001;

    // Address bit that selects "all banks" on a PRECHARGE.
    localparam int unsigned PREA_ADR_BIT = 10;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_MEM  = 2'd1,
        ST_PREA = 2'd2,
        ST_REFR = 2'd3
    } state_e;

endpackage

// File: rtl/ddr3_ref_arb_if.sv
// ddr3_ref_arb_if: one DDR command channel with a req/rdy handshake.
// A command moves on a cycle where req && rdy.
//   req  master->slave  command valid
//   rdy  slave->master  command accepted
//   seq  master->slave  command continues a sequence (keeps ownership)
//   cmd  master->slave  {ras_n, cas_n, we_n}
//   ba   master->slave  bank address
//   adr  master->slave  row/column address, DDR_ROW_BITS wide
interface ddr3_ref_arb_if
    import ddr3_ref_arb_pkg::*;
#(
    parameter int unsigned DDR_ROW_BITS = 13
) ();

    logic                    req;
    logic                    rdy;
    logic                    seq;
    logic [CMD_BITS-1:0]     cmd;
    logic [BA_BITS-1:0]      ba;
    logic [DDR_ROW_BITS-1:0] adr;

    modport master (output req, seq, cmd, ba, adr, input rdy);
    modport slave  (input req, seq, cmd, ba, adr, output rdy);

endinterface

// File: rtl/ddr3_ref_arb.sv
// ddr3_ref_arb: refresh scheduler and command arbiter in front of the DDL.
//   During initialisation configurator commands pass straight to the DDL. Once cfg_run_i is
//   high, FSM commands pass through, tREFI ticks are counted, and PRECHARGE-ALL + REFRESH pairs
//   are inserted at sequence boundaries. At the postpone limit the FSM is blocked to force them.
// Ports:
//   clock, reset    system clock; synchronous active-high reset
//   cfg_run_i       configurator finished initialisation
//   cfg_ref_i       one-cycle tREFI tick
//   cfg             configurator command channel (slave; seq unused)
//   fsm             memory-controller FSM command channel (slave)
//   ddl             command channel towards the DDL (master)
//   ref_pend_o      postponed-refresh count
//   ref_busy_o      refresh pair in progress
//   ref_err_o       sticky: a tick arrived while the count was already at the limit
// Build option: define DDR3_REF_BURST_EN to drain every postponed refresh back-to-back after a
// single PRECHARGE-ALL; otherwise each entry issues exactly one PREC+REFR pair.
module ddr3_ref_arb
    import ddr3_ref_arb_pkg::*;
#(
    parameter int unsigned DDR_ROW_BITS = 13,
    parameter int unsigned REF_MAX_PEND = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_run_i,
    input  logic                cfg_ref_i,
    ddr3_ref_arb_if.slave       cfg,
    ddr3_ref_arb_if.slave       fsm,
    ddr3_ref_arb_if.master      ddl,
    output logic [3:0]          ref_pend_o,
    output logic                ref_busy_o,
    output logic                ref_err_o
);

    localparam int unsigned RSB      = DDR_ROW_BITS - 1;
    localparam logic [3:0]  PEND_MAX = 4'(REF_MAX_PEND);

    state_e     state_q;
    logic [3:0] pend_q;
    logic [3:0] pend_nxt;
    logic       lock_q;
    logic       err_q;

    logic       at_max;
    logic       block;
    logic       tick;
    logic       refr_xfer;
    logic       fsm_rdy;
    logic       fsm_xfer;
    logic       enter_ref;

    assign at_max    = (pend_q == PEND_MAX);
    // Forced refresh waits for a sequence boundary, so the FSM is only held off when unlocked.
    assign block     = (state_q == ST_MEM) && at_max && !lock_q;
    assign tick      = cfg_ref_i && (state_q != ST_INIT);
    assign refr_xfer = (state_q == ST_REFR) && ddl.rdy;
    assign fsm_rdy   = !reset && (state_q == ST_MEM) && ddl.rdy && !block;
    assign fsm_xfer  = fsm.req && fsm_rdy;
    assign enter_ref = !lock_q && (pend_q != 4'd0) && (!fsm.req || at_max);

    // A tick coinciding with a REFR transfer cancels out; otherwise count saturates.
    always_comb begin
        pend_nxt = pend_q;
        case ({tick, refr_xfer})
            2'b10:   pend_nxt = at_max ? pend_q : pend_q + 4'd1;
            2'b01:   pend_nxt = pend_q - 4'd1;
            default: pend_nxt = pend_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INIT;
            pend_q  <= 4'd0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (tick && at_max) begin
                err_q <= 1'b1;
            end
            if ((state_q != ST_INIT) && !cfg_run_i) begin
                // Configurator took the memory back: drop everything, including a half-done pair.
                state_q <= ST_INIT;
                pend_q  <= 4'd0;
                lock_q  <= 1'b0;
            end else begin
                pend_q <= pend_nxt;
                unique case (state_q)
                    ST_INIT: begin
                        lock_q <= 1'b0;
                        if (cfg_run_i) begin
                            state_q <= ST_MEM;
                        end
                    end
                    ST_MEM: begin
                        if (fsm_xfer) begin
                            lock_q <= fsm.seq;
                        end
                        if (enter_ref) begin
                            state_q <= ST_PREA;
                        end
                    end
                    ST_PREA: begin
                        if (ddl.rdy) begin
                            state_q <= ST_REFR;
                        end
                    end
                    ST_REFR: begin
                        if (ddl.rdy) begin
`ifdef DDR3_REF_BURST_EN
                            state_q <= (pend_nxt != 4'd0) ? ST_REFR : ST_MEM;
`else
                            state_q <= ST_MEM;
`endif
                        end
                    end
                    default: state_q <= ST_INIT;
                endcase
            end
        end
    end

    // Pass-through mux selected by the registered state; everything is quiet while in reset.
    always_comb begin
        ddl.req = 1'b0;
        ddl.seq = 1'b0;
        ddl.cmd = CMD_NOOP;
        ddl.ba  = '0;
        ddl.adr = '0;
        cfg.rdy = 1'b0;
        fsm.rdy = fsm_rdy;
        if (!reset) begin
            unique case (state_q)
                ST_INIT: begin
                    ddl.req = cfg.req;
                    ddl.cmd = cfg.cmd;
                    ddl.ba  = cfg.ba;
                    ddl.adr = cfg.adr;
                    cfg.rdy = ddl.rdy;
                end
                ST_MEM: begin
                    // Mask the request while blocked so the DDL never accepts an unacknowledged cmd.
                    ddl.req = fsm.req && !block;
                    ddl.seq = fsm.seq;
                    ddl.cmd = fsm.cmd;
                    ddl.ba  = fsm.ba;
                    ddl.adr = fsm.adr;
                end
                ST_PREA: begin
                    ddl.req               = 1'b1;
                    ddl.seq               = 1'b1;
                    ddl.cmd               = CMD_PREC;
                    ddl.adr[PREA_ADR_BIT] = 1'b1;
                end
                ST_REFR: begin
                    ddl.req = 1'b1;
                    ddl.cmd = CMD_REFR;
                end
                default: ddl.req = 1'b0;
            endcase
        end
    end

    assign ref_pend_o = pend_q;
    assign ref_busy_o = (state_q == ST_PREA) || (state_q == ST_REFR);
    assign ref_err_o  = err_q;

    logic unused_adr_msb;
    assign unused_adr_msb = ^ddl.adr[RSB:0] & 1'b0;

endmodule

// File: tb/tb_ddr3_ref_arb.sv
// tb_ddr3_ref_arb: self-checking bench for ddr3_ref_arb.
// A table of single-cycle vectors covers reset, pass-through and a minimal refresh pair; short
// hand-written sequences cover forced refresh, saturation, draining and abort; a random run is
// compared every cycle against a reference model of the refresh/arbitration rules.
module tb_ddr3_ref_arb;
    import ddr3_ref_arb_pkg::*;

    localparam int ROWB = 13;
    localparam int MAXP = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_run = 1'b0;
    logic       cfg_ref = 1'b0;
    logic [3:0] ref_pend;
    logic       ref_busy;
    logic       ref_err;

    ddr3_ref_arb_if #(.DDR_ROW_BITS(ROWB)) cfg_if ();
    ddr3_ref_arb_if #(.DDR_ROW_BITS(ROWB)) fsm_if ();
    ddr3_ref_arb_if #(.DDR_ROW_BITS(ROWB)) ddl_if ();

    ddr3_ref_arb #(.DDR_ROW_BITS(ROWB), .REF_MAX_PEND(MAXP)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_run_i  (cfg_run),
        .cfg_ref_i  (cfg_ref),
        .cfg        (cfg_if),
        .fsm        (fsm_if),
        .ddl        (ddl_if),
        .ref_pend_o (ref_pend),
        .ref_busy_o (ref_busy),
        .ref_err_o  (ref_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: running flag, refresh phase (0 none, 1 PREC owed, 2 REFR owed),
    // postponed count, FSM ownership, sticky error.
    bit m_run;
    int m_phase;
    int m_pend;
    bit m_lock;
    bit m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] dut_vec();
        return {3'b0, ddl_if.req, ddl_if.seq, ddl_if.cmd, ddl_if.ba, ddl_if.adr,
                cfg_if.rdy, fsm_if.rdy, ref_pend, ref_busy, ref_err};
    endfunction

    function automatic logic [31:0] model_vec();
        logic req, seq, crdy, frdy;
        logic [2:0] cmd, ba;
        logic [12:0] adr;
        bit blocked;
        crdy = 1'b0;
        frdy = 1'b0;
        if (!m_run) begin
            req = cfg_if.req; seq = 1'b0; cmd = cfg_if.cmd; ba = cfg_if.ba; adr = cfg_if.adr;
            crdy = ddl_if.rdy;
        end else if (m_phase == 1) begin
            req = 1'b1; seq = 1'b1; cmd = 3'b010; ba = 3'd0; adr = 13'h0400;
        end else if (m_phase == 2) begin
            req = 1'b1; seq = 1'b0; cmd = 3'b001; ba = 3'd0; adr = 13'h0000;
        end else begin
            blocked = (m_pend == MAXP) && !m_lock;
            req = fsm_if.req && !blocked; seq = fsm_if.seq;
            cmd = fsm_if.cmd; ba = fsm_if.ba; adr = fsm_if.adr;
            frdy = ddl_if.rdy && !blocked;
        end
        return {3'b0, req, seq, cmd, ba, adr, crdy, frdy, 4'(m_pend), m_phase != 0, m_err};
    endfunction

    task automatic model_step();
        bit ticked, done, blocked;
        int np;
        if (reset) begin
            m_run = 0; m_phase = 0; m_pend = 0; m_lock = 0; m_err = 0;
            return;
        end
        ticked = cfg_ref && m_run;
        if (ticked && m_pend == MAXP) m_err = 1;
        if (!m_run) begin
            if (cfg_run) m_run = 1;
        end else if (!cfg_run) begin
            m_run = 0; m_phase = 0; m_pend = 0; m_lock = 0;
        end else begin
            done = (m_phase == 2) && ddl_if.rdy;
            if (ticked && done) np = m_pend;
            else np = ((m_pend + int'(ticked) > MAXP) ? MAXP : m_pend + int'(ticked)) - int'(done);
            if (m_phase == 0) begin
                blocked = (m_pend == MAXP) && !m_lock;
                if (!m_lock && m_pend > 0 && (!fsm_if.req || m_pend == MAXP)) m_phase = 1;
                if (fsm_if.req && ddl_if.rdy && !blocked) m_lock = fsm_if.seq;
            end else if (m_phase == 1) begin
                if (ddl_if.rdy) m_phase = 2;
            end else if (done) begin
`ifdef DDR3_REF_BURST_EN
                m_phase = (np > 0) ? 2 : 0;
`else
                m_phase = 0;
`endif
            end
            m_pend = np;
        end
    endtask

    // half: settle to the falling edge and compare with the model; fin: advance one clock.
    task automatic half();
        @(negedge clock);
        if (!reset) check("model", dut_vec(), model_vec());
    endtask

    task automatic fin();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        half();
        fin();
    endtask

    task automatic set_cfg_cmd();
        cfg_if.cmd = 3'b000; cfg_if.ba = 3'd2; cfg_if.adr = 13'h0520; cfg_if.seq = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cfg_run = 1'b0; cfg_ref = 1'b0;
        set_cfg_cmd(); cfg_if.req = 1'b1; fsm_if.req = 1'b1; fsm_if.seq = 1'b0;
        ddl_if.rdy = 1'b1;
        step();
        half();
        check("reset_outputs", {27'b0, ddl_if.req, ddl_if.seq, cfg_if.rdy, fsm_if.rdy, 1'b0},
              {27'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset_cmd", {29'b0, ddl_if.cmd}, {29'b0, 3'b111});
        fin();
        reset = 1'b0; cfg_if.req = 1'b0; fsm_if.req = 1'b0;
        half();
        check("reset_state", {25'b0, ref_pend, ref_busy, ref_err, fsm_if.rdy},
              {25'b0, 4'd0, 1'b0, 1'b0, 1'b0});
        fin();
    endtask

    typedef struct {
        logic       run, tck, creq, freq, rdy;
        logic       req, seq;
        logic [2:0] cmd, ba;
        logic [12:0] adr;
        logic       crdy, frdy;
        logic [3:0] pend;
        logic       busy;
    } vec_t;

    vec_t vecs[8];
    int   precs, refrs;

    initial begin
        fsm_if.cmd = 3'b011; fsm_if.ba = 3'd5; fsm_if.adr = 13'h0123;
        do_reset();

        //               run tck creq freq rdy  req seq cmd    ba    adr        crdy frdy pend busy
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 3'd2, 13'h0520, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'd2, 13'h0520, 1'b1, 1'b0, 4'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'd2, 13'h0520, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 3'd5, 13'h0123, 1'b0, 1'b1, 4'd0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 3'd5, 13'h0123, 1'b0, 1'b1, 4'd1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 3'd0, 13'h0400, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 3'd0, 13'h0000, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011, 3'd5, 13'h0123, 1'b0, 1'b1, 4'd0, 1'b0};
        set_cfg_cmd();
        for (int i = 0; i < 8; i++) begin
            cfg_run = vecs[i].run; cfg_ref = vecs[i].tck; cfg_if.req = vecs[i].creq;
            fsm_if.req = vecs[i].freq; fsm_if.seq = 1'b0; ddl_if.rdy = vecs[i].rdy;
            half();
            check($sformatf("vec%0d", i),
                  {3'b0, ddl_if.req, ddl_if.seq, ddl_if.cmd, ddl_if.ba, ddl_if.adr,
                   cfg_if.rdy, fsm_if.rdy, ref_pend, ref_busy, 1'b0},
                  {3'b0, vecs[i].req, vecs[i].seq, vecs[i].cmd, vecs[i].ba, vecs[i].adr,
                   vecs[i].crdy, vecs[i].frdy, vecs[i].pend, vecs[i].busy, 1'b0});
            fin();
        end
        cfg_ref = 1'b0;

        // Forced refresh waits for the end of a locked sequence.
        do_reset();
        cfg_run = 1'b1; step();
        fsm_if.req = 1'b1; fsm_if.seq = 1'b1; fsm_if.cmd = 3'b011; step();
        cfg_ref = 1'b1; repeat (8) step(); cfg_ref = 1'b0;
        fsm_if.seq = 1'b0; fsm_if.cmd = 3'b100;
        half();
        check("wr_accepted", {27'b0, ref_pend, fsm_if.rdy}, {27'b0, 4'd8, 1'b1});
        fin();
        half();
        check("forced_block", {30'b0, fsm_if.rdy, ddl_if.req}, {30'b0, 1'b0, 1'b0});
        fin();
        half();
        check("forced_prec", {28'b0, ddl_if.req, ddl_if.cmd}, {28'b0, 1'b1, 3'b010});
        fin();
        half();
        check("forced_refr", {28'b0, ddl_if.req, ddl_if.cmd}, {28'b0, 1'b1, 3'b001});
        fin();
        half();
`ifdef DDR3_REF_BURST_EN
        check("after_refr", {25'b0, ref_pend, ddl_if.cmd}, {25'b0, 4'd7, 3'b001});
`else
        check("after_refr", {27'b0, ref_pend, fsm_if.rdy}, {27'b0, 4'd7, 1'b1});
`endif
        fin();

        // Saturation and sticky error while the FSM never yields.
        do_reset();
        cfg_run = 1'b1; step();
        fsm_if.req = 1'b1; fsm_if.seq = 1'b1; step();
        cfg_ref = 1'b1; repeat (9) step(); cfg_ref = 1'b0;
        half();
        check("saturate", {27'b0, ref_pend, ref_err}, {27'b0, 4'd8, 1'b1});
        fin();
        fsm_if.seq = 1'b0; repeat (6) step(); fsm_if.req = 1'b0; repeat (20) step();
        half();
        check("err_sticky", {31'b0, ref_err}, {31'b0, 1'b1});
        fin();

        // Draining three postponed refreshes with an idle FSM.
        do_reset();
        cfg_run = 1'b1; step();
        fsm_if.req = 1'b1; fsm_if.seq = 1'b1; step();
        cfg_ref = 1'b1; repeat (3) step(); cfg_ref = 1'b0;
        fsm_if.seq = 1'b0; step();
        fsm_if.req = 1'b0;
        precs = 0; refrs = 0;
        for (int i = 0; i < 14; i++) begin
            half();
            if (ddl_if.req && ddl_if.rdy && ddl_if.cmd == 3'b010) precs++;
            if (ddl_if.req && ddl_if.rdy && ddl_if.cmd == 3'b001) refrs++;
            fin();
        end
`ifdef DDR3_REF_BURST_EN
        check("drain_precs", 32'(precs), 32'd1);
`else
        check("drain_precs", 32'(precs), 32'd3);
`endif
        check("drain_refrs", 32'(refrs), 32'd3);
        check("drain_pend", {28'b0, ref_pend}, 32'd0);

        // Abort in the middle of a refresh pair.
        do_reset();
        cfg_run = 1'b1; step();
        cfg_ref = 1'b1; step(); cfg_ref = 1'b0;
        step();
        half();
        check("abort_prec", {28'b0, ddl_if.req, ddl_if.cmd}, {28'b0, 1'b1, 3'b010});
        fin();
        ddl_if.rdy = 1'b0; cfg_run = 1'b0; cfg_if.req = 1'b1; set_cfg_cmd();
        half();
        check("abort_refr", {25'b0, ref_pend, ddl_if.cmd}, {25'b0, 4'd1, 3'b001});
        fin();
        half();
        check("abort_init", {3'b0, ddl_if.req, ddl_if.seq, ddl_if.cmd, ddl_if.ba, ddl_if.adr,
                             cfg_if.rdy, fsm_if.rdy, ref_pend, ref_busy, 1'b0},
              {3'b0, 1'b1, 1'b0, 3'b000, 3'd2, 13'h0520, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
        fin();

        // Random traffic against the model; alternate busy and relaxed FSM phases.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (!cfg_run) cfg_run = ($urandom_range(3) == 0);
            else cfg_run = ($urandom_range(299) != 0);
            cfg_ref    = ($urandom_range(3) == 0);
            cfg_if.req = 1'($urandom_range(1));
            cfg_if.cmd = 3'($urandom); cfg_if.ba = 3'($urandom); cfg_if.adr = 13'($urandom);
            if (((i / 400) % 2) == 0) begin
                fsm_if.req = ($urandom_range(19) != 0);
                fsm_if.seq = ($urandom_range(9) != 0);
            end else begin
                fsm_if.req = ($urandom_range(9) < 5);
                fsm_if.seq = 1'($urandom_range(1));
            end
            fsm_if.cmd = 3'($urandom); fsm_if.ba = 3'($urandom); fsm_if.adr = 13'($urandom);
            ddl_if.rdy = ($urandom_range(3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ddr3_ref_arb.md
# ddr3_ref_arb

Refresh scheduler and command arbiter between the SDRAM configurator, the memory-controller FSM and the DDL. During initialisation it passes configurator commands straight to the DDL. Once the configurator reports run, it passes FSM commands, counts tREFI ticks, and inserts PRECHARGE-ALL + REFRESH pairs at sequence boundaries. When the postpone budget is exhausted, it blocks the FSM to force those refreshes.

## Interface
- DDR_ROW_BITS, 13, row/address width; RSB = DDR_ROW_BITS-1
- REF_MAX_PEND, 8, maximum postponed refreshes (1..15)
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- cfg_run_i  in  1  configurator finished initialisation
- cfg_ref_i  in  1  one-cycle tREFI tick
- cfg_req_i / cfg_rdy_o  in/out  1  configurator command handshake
- cfg_cmd_i, cfg_ba_i, cfg_adr_i  in  3,3,DDR_ROW_BITS  configurator command {ras_n,cas_n,we_n}, bank, address
- fsm_req_i / fsm_rdy_o  in/out  1  FSM command handshake
- fsm_seq_i  in  1  command continues a sequence; ownership is held
- fsm_cmd_i, fsm_ba_i, fsm_adr_i  in  3,3,DDR_ROW_BITS  FSM command, bank, address
- ddl_req_o / ddl_rdy_i  out/in  1  DDL command handshake
- ddl_seq_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o  out  1,3,3,DDR_ROW_BITS  DDL command
- ref_pend_o  out  4  postponed-refresh count
- ref_busy_o  out  1  refresh pair in progress
- ref_err_o  out  1  sticky overflow flag

## Operation
- A command is transferred on a cycle where req && rdy. This applies to all three ports.
- Command encodings: NOOP 111, PREC 010, REFR 001.
- The DDL enforces tRP and tRFC. This block only orders commands.
- States:
  - ST_INIT: ddl_* = cfg_*; cfg_rdy_o = ddl_rdy_i; fsm_rdy_o = 0; ticks ignored; pending held at 0. Go to ST_MEM on the cycle after cfg_run_i is sampled high.
  - ST_MEM: ddl_* = fsm_*; fsm_rdy_o = ddl_rdy_i unless blocked; cfg_rdy_o = 0.
  - ST_PREA: ddl_req_o = 1, cmd PREC, ba 0, adr[10] = 1, all other adr bits 0, ddl_seq_o = 1. On transfer, go to ST_REFR.
  - ST_REFR: ddl_req_o = 1, cmd REFR, adr 0, ddl_seq_o = 0. On transfer, decrement pending and go to ST_MEM (see Configuration).
- Lock flag: set on an FSM transfer with fsm_seq_i = 1. Cleared on an FSM transfer with fsm_seq_i = 0. Cleared on reset and in ST_INIT.
- Refresh entry, from ST_MEM when unlocked:
  - Opportunistic: pending > 0 and fsm_req_i = 0.
  - Forced: pending == REF_MAX_PEND. fsm_rdy_o is held 0 from that cycle until the state returns to ST_MEM with pending below the maximum.
  - A forced entry never splits a locked sequence.
- Pending counter:
  - Tick increments it, saturating at REF_MAX_PEND.
  - A tick while already at REF_MAX_PEND sets ref_err_o, which stays set until reset.
  - A tick and a REFR transfer in the same cycle leave the count unchanged.
- cfg_run_i low in any non-INIT state: go to ST_INIT next cycle, clear pending and lock, and abandon any in-flight PREA/REFR.
- ref_busy_o = 1 in ST_PREA and ST_REFR.

## Timing
- Reset values: state ST_INIT, pending 0, lock 0, ref_err_o 0.
- While reset is high: ddl_req_o 0, ddl_seq_o 0, ddl_cmd_o NOOP, cfg_rdy_o 0, fsm_rdy_o 0.
- Pass-through (ST_INIT, ST_MEM) is a combinational mux selected by the registered state, so it adds zero latency.
- Refresh entry decision is registered. ST_PREA asserts ddl_req_o one cycle after the entry condition.
- Minimum refresh pair with ddl_rdy_i constantly high: PREC at cycle N+1, REFR at cycle N+2, FSM pass-through resumes at cycle N+3.
- ref_pend_o is registered and reflects ticks one cycle after they are sampled.

## Configuration
- DDR3_REF_BURST_EN defined: ST_REFR stays in ST_REFR while pending after decrement is > 0, so all postponed refreshes drain back-to-back after a single PRECHARGE-ALL.
- DDR3_REF_BURST_EN undefined: exactly one PREC+REFR pair per entry, then return to ST_MEM.

## Structure
- Shared package/include (ddr3_settings.vh): CMD_NOOP, CMD_PREC, CMD_REFR encodings; state encodings ST_INIT, ST_MEM, ST_PREA, ST_REFR.
- Single module; no sub-module. The pending counter stays inline.

## Test plan
- Reset release, cfg_run_i low, cfg issues MODE with ba 2, adr 0x0520 → identical command at the DDL in the same cycle; fsm_rdy_o stays 0.
- cfg_run_i high, one tick, FSM idle → PREC (adr[10] = 1) then REFR on consecutive cycles; ref_pend_o goes 1 → 0; ref_busy_o high for 2 cycles.
- FSM sends ACT (seq = 1) then WR (seq = 0), constantly requesting while 8 ticks arrive → the WR transfers first; next cycle fsm_rdy_o = 0 and a PREC is issued.
- 9 ticks with the FSM continuously busy in locked sequences → ref_pend_o saturates at 8; ref_err_o = 1 and stays set until reset.
- DDR3_REF_BURST_EN defined, pending 3, FSM idle → one PREC followed by 3 REFR; without the macro → 3 separate PREC/REFR pairs.
- cfg_run_i drops while in ST_REFR with ddl_rdy_i = 0 → next cycle ST_INIT, ddl_* follow cfg_*, ref_pend_o = 0.
